// File: rtl/tt_sweep_reader_if.sv
// Handshake/bus bundle between the sweep controller side and tt_sweep_reader.
// TT_CMP_EN adds the expected-table input and the match flag.
interface tt_sweep_reader_if #(
  parameter int N_IN = 7
);
  localparam int W = 1 << N_IN;

  logic            start;
  logic            abort;
  logic [N_IN-1:0] vec;
  logic            f_in;
  logic            busy;
  logic            done;
  logic [W-1:0]    tt;
`ifdef TT_CMP_EN
  logic [W-1:0]    exp_tt;
  logic            match;

  modport master (
    output start, abort, f_in, exp_tt,
    input  vec, busy, done, tt, match
  );
  modport slave (
    input  start, abort, f_in, exp_tt,
    output vec, busy, done, tt, match
  );
`else
  modport master (
    output start, abort, f_in,
    input  vec, busy, done, tt
  );
  modport slave (
    input  start, abort, f_in,
    output vec, busy, done, tt
  );
`endif
endinterface

// File: rtl/tt_sweep_reader.sv
// Sweeps every input vector through a combinational network and captures its truth table.
// Optional TT_CMP_EN builds a full-width compare against an expected table.
module tt_sweep_reader #(
  parameter int N_IN   = 7,
  parameter int SETTLE = 0
) (
  input  logic clk,
  input  logic rst_n,
  tt_sweep_reader_if.slave bus
);
  localparam int W = 1 << N_IN;
  localparam logic [N_IN:0] LAST = (N_IN+1)'(W - 1);
  localparam logic [N_IN:0] ONE  = (N_IN+1)'(1);
  localparam logic [3:0]    SET  = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N_IN:0] idx_q, idx_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [W-1:0]  tt_q, tt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          match_q, match_d;
  logic          eq;

`ifdef TT_CMP_EN
  assign eq = (tt_d == bus.exp_tt);
`else
  assign eq = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    match_d = match_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_APPLY;
          idx_d   = '0;
          cnt_d   = '0;
          tt_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          match_d = 1'b0;
        end
      end
      S_APPLY: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          match_d = 1'b0;
        end else if (cnt_q != SET) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          tt_d[idx_q[N_IN-1:0]] = bus.f_in;
          if (idx_q == LAST) begin
            // vec keeps the last vector while DONE
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = eq;
          end else begin
            idx_d = idx_q + ONE;
            cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        match_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign bus.vec  = idx_q[N_IN-1:0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tt   = tt_q;
`ifdef TT_CMP_EN
  assign bus.match = match_q;
`else
  logic unused_match;
  assign unused_match = match_q;
`endif

endmodule

// File: tb/tb_tt_sweep_reader.sv
// Directed + random bench for tt_sweep_reader: SETTLE=0 and SETTLE=3 instances
// fed by a table-driven network model.
module tb_tt_sweep_reader;
  localparam int N = 7;
  localparam int W = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] net_tt = '0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tt_sweep_reader_if #(.N_IN(N)) bus0 ();
  tt_sweep_reader_if #(.N_IN(N)) bus3 ();

  assign bus0.f_in = net_tt[bus0.vec];
  assign bus3.f_in = net_tt[bus3.vec];

  tt_sweep_reader #(.N_IN(N), .SETTLE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );
  tt_sweep_reader #(.N_IN(N), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
  );

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start0();
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
  endtask

  task automatic wait_done0(output int cyc);
    cyc = 0;
    while (bus0.done !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic logic [W-1:0] maj_table();
    logic [W-1:0] t;
    for (int v = 0; v < W; v++)
      t[v] = (v[0] + v[1] + v[2]) >= 2;
    return t;
  endfunction

  initial begin
    int cyc;
    int mism;
    int k;
    logic [W-1:0] one;
    logic [W-1:0] exp_v;
    logic [W-1:0] first;
    one = 1;
    bus0.start = 0; bus0.abort = 0;
    bus3.start = 0; bus3.abort = 0;
`ifdef TT_CMP_EN
    bus0.exp_tt = '0;
    bus3.exp_tt = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_vec", bus0.vec, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_tt", bus0.tt, 0);
    chk("rst3_tt", bus3.tt, 0);
`ifdef TT_CMP_EN
    chk("rst_match", bus0.match, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // constant-zero network
    net_tt = '0;
    start0();
    chk("start_busy", bus0.busy, 1);
    chk("start_vec", bus0.vec, 0);
    wait_done0(cyc);
    chk("zero_cycles", cyc, 128);
    chk("zero_tt", bus0.tt, 0);
    chk("zero_busy", bus0.busy, 0);
`ifdef TT_CMP_EN
    chk("zero_match", bus0.match, 1);
`endif

    // abort in DONE has no effect
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    chk("abort_done_done", bus0.done, 1);
    chk("abort_done_vec", bus0.vec, 127);

    // majority of x0..x2
    net_tt = maj_table();
    start0();
    wait_done0(cyc);
    chk("maj_cycles", cyc, 128);
    chk("maj_tt", bus0.tt, {16{8'hE8}});

    // SETTLE=3: each vector held 4 cycles
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    mism = 0;
    for (int s = 0; s < 512; s++) begin
      if (bus3.vec !== 7'(s / 4) || bus3.done !== 1'b0 || bus3.busy !== 1'b1)
        mism++;
      @(negedge clk);
    end
    chk("s3_vec_hold", mism, 0);
    chk("s3_done_512", bus3.done, 1);
    chk("s3_tt", bus3.tt, {16{8'hE8}});

    // golden classified function
    net_tt = 128'hfeeaeaaaeee8e888eee8e888aaa8a880;
`ifdef TT_CMP_EN
    bus0.exp_tt = net_tt;
`endif
    start0();
    wait_done0(cyc);
    chk("gold_tt", bus0.tt, 128'hfeeaeaaaeee8e888eee8e888aaa8a880);
`ifdef TT_CMP_EN
    chk("gold_match", bus0.match, 1);
    bus0.exp_tt = net_tt ^ (one << 5);
    start0();
    chk("match_clr", bus0.match, 0);
    wait_done0(cyc);
    chk("gold_mis", bus0.match, 0);
`endif

    // back-to-back random tables
    for (int r = 0; r < 4; r++) begin
      net_tt = {$urandom, $urandom, $urandom, $urandom};
      start0();
      chk("b2b_done_drop", bus0.done, 0);
      chk("b2b_tt_clr", bus0.tt, 0);
      wait_done0(cyc);
      chk("rnd_cycles", cyc, 128);
      chk("rnd_tt", bus0.tt, net_tt);
      first = bus0.tt;
      start0();
      wait_done0(cyc);
      chk("b2b_same", bus0.tt, first);
    end

    // abort after capture 10 with start ignored mid-sweep
    net_tt = '1;
    start0();
    repeat (5) @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    chk("ign_vec", bus0.vec, 6);
    chk("ign_busy", bus0.busy, 1);
    repeat (4) @(negedge clk);
    bus0.abort = 1'b1;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    bus0.start = 1'b0;
    chk("abort_tt", bus0.tt, 128'h3FF);
    chk("abort_busy", bus0.busy, 0);
    chk("abort_done", bus0.done, 0);
    chk("abort_vec", bus0.vec, 0);

    // random abort points
    for (int r = 0; r < 3; r++) begin
      net_tt = {$urandom, $urandom, $urandom, $urandom};
      k = $urandom_range(1, 126);
      start0();
      repeat (k) @(negedge clk);
      bus0.abort = 1'b1;
      @(negedge clk);
      bus0.abort = 1'b0;
      exp_v = net_tt & ((one << k) - one);
      chk("rnd_abort_tt", bus0.tt, exp_v);
      chk("rnd_abort_busy", bus0.busy, 0);
    end

    // reset mid-sweep at capture 40
    net_tt = maj_table();
    start0();
    repeat (40) @(negedge clk);
    chk("pre_rst_vec", bus0.vec, 40);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vec", bus0.vec, 0);
    chk("mid_rst_busy", bus0.busy, 0);
    chk("mid_rst_done", bus0.done, 0);
    chk("mid_rst_tt", bus0.tt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start0();
    wait_done0(cyc);
    chk("post_rst_cycles", cyc, 128);
    chk("post_rst_tt", bus0.tt, {16{8'hE8}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
